// File: rtl/word_loader.sv
// ---------------------------------------------------------------------------
// word_loader
//
// Purpose:
//   Assembles a stream of bytes into 32-bit words and presents each finished
//   word to a downstream 32-bit register that is clocked through a gated
//   clock. The enable for that gate (wr_en) comes straight from a flop, so it
//   only changes just after a rising clk edge while clk is high, which keeps
//   the downstream gated clock glitch-free.
//
//   Two states:
//     FILL   - bytes are accepted and written into a staging register.
//     COMMIT - the assembled word sits on D and wr_en is high for one cycle.
//              The downstream register captures D on the edge that ends
//              COMMIT. No bytes are accepted in this state.
//
// Parameters:
//   LSB_FIRST     1: first byte of a word lands in D[7:0]
//                 0: first byte of a word lands in D[31:24]
//
// Ports:
//   clk           in   1   single clock, all flops rising-edge
//   rst           in   1   asynchronous active-high reset
//   byte_in       in   8   incoming data byte
//   byte_valid    in   1   byte_in is valid this cycle
//   byte_ready    out  1   block accepts a byte this cycle (state decode)
//   flush         in   1   discard the partially assembled word (FILL only)
//   D             out  32  assembled word for the downstream register
//   wr_en         out  1   one-cycle write enable per committed word
//   byte_idx      out  2   number of bytes held in the current partial word
//   words_written out  16  saturating count of committed words
// ---------------------------------------------------------------------------
module word_loader #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic        flush,
  output logic [31:0] D,
  output logic        wr_en,
  output logic [1:0]  byte_idx,
  output logic [15:0] words_written
);

  typedef enum logic {
    FILL   = 1'b0,
    COMMIT = 1'b1
  } state_t;

  state_t      state_q;
  logic [1:0]  byteIdx_q;
  logic [31:0] staging_q;
  logic [31:0] staging_d;
  logic [31:0] dOut_q;
  logic        wrEn_q;
  logic [15:0] wordsWritten_q;
  logic [15:0] wordsWritten_d;
  logic [1:0]  lane;
  logic        accept;

  // Handshake and lane selection. byte_ready depends on the state flop only,
  // so there is no combinational path from any input to byte_ready.
  always_comb begin
    accept = byte_valid && (state_q == FILL);
    if (LSB_FIRST) begin
      lane = byteIdx_q;
    end else begin
      lane = 2'd3 - byteIdx_q;
    end
  end

  // Staging register with the incoming byte merged into its lane. Using the
  // merged value for the commit lets the fourth byte reach D on the same edge
  // it is accepted.
  always_comb begin
    staging_d = staging_q;
    case (lane)
      2'd0:    staging_d[7:0]   = byte_in;
      2'd1:    staging_d[15:8]  = byte_in;
      2'd2:    staging_d[23:16] = byte_in;
      default: staging_d[31:24] = byte_in;
    endcase
  end

  // Saturating increment of the committed-word counter.
  always_comb begin
    if (wordsWritten_q == 16'hFFFF) begin
      wordsWritten_d = wordsWritten_q;
    end else begin
      wordsWritten_d = wordsWritten_q + 16'd1;
    end
  end

  // Main FSM. All outputs are flops updated here. A flush in FILL wins over a
  // simultaneous byte, so that byte is consumed (ready was high) but never
  // stored. In COMMIT flush is ignored and the word always completes. D is
  // only loaded on the FILL->COMMIT transition and otherwise holds, so it is
  // stable throughout and after the wr_en pulse. An asynchronous reset during
  // COMMIT drops wr_en immediately, so the downstream gated clock never gets
  // its closing edge and the word is lost without being counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= FILL;
      byteIdx_q      <= 2'd0;
      staging_q      <= 32'h0;
      dOut_q         <= 32'h0;
      wrEn_q         <= 1'b0;
      wordsWritten_q <= 16'h0;
    end else begin
      case (state_q)
        FILL: begin
          wrEn_q <= 1'b0;
          if (flush) begin
            byteIdx_q <= 2'd0;
          end else if (accept) begin
            staging_q <= staging_d;
            if (byteIdx_q == 2'd3) begin
              dOut_q    <= staging_d;
              byteIdx_q <= 2'd0;
              wrEn_q    <= 1'b1;
              state_q   <= COMMIT;
            end else begin
              byteIdx_q <= byteIdx_q + 2'd1;
            end
          end
        end
        COMMIT: begin
          wrEn_q         <= 1'b0;
          state_q        <= FILL;
          wordsWritten_q <= wordsWritten_d;
        end
        default: begin
          wrEn_q  <= 1'b0;
          state_q <= FILL;
        end
      endcase
    end
  end

  assign byte_ready    = (state_q == FILL);
  assign D             = dOut_q;
  assign wr_en         = wrEn_q;
  assign byte_idx      = byteIdx_q;
  assign words_written = wordsWritten_q;

endmodule

// File: tb/tb_word_loader.sv
// ---------------------------------------------------------------------------
// tb_word_loader
//
// Purpose:
//   Drives one shared byte stream into two word_loader instances, one built
//   with LSB_FIRST=1 and one with LSB_FIRST=0. A reference model tracks the
//   expected state; each finished word is pushed to a per-instance queue and
//   popped when that instance raises wr_en. A vector table covers the main
//   stream; hand-written sequences cover asynchronous reset during COMMIT,
//   reset mid-word and counter saturation.
// ---------------------------------------------------------------------------
module tb_word_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  byteIn;
  logic        byteValid;
  logic        flush;

  logic        readyLsb, readyMsb;
  logic [31:0] dLsb, dMsb;
  logic        wrEnLsb, wrEnMsb;
  logic [1:0]  idxLsb, idxMsb;
  logic [15:0] wwLsb, wwMsb;

  int compared;
  int mismatched;

  // Reference model state
  logic        mFill;
  int          mIdx;
  logic        mWr;
  logic [15:0] mCount;
  logic [31:0] mStageLsb, mStageMsb;
  logic [31:0] heldLsb, heldMsb;
  logic [31:0] qLsb[$];
  logic [31:0] qMsb[$];

  typedef struct {
    logic [7:0] b;
    logic       v;
    logic       f;
    logic [1:0] expIdx;
    logic       expWr;
  } vec_t;

  vec_t vecs[29];

  word_loader #(.LSB_FIRST(1'b1)) uLsb (
    .clk(clk), .rst(rst), .byte_in(byteIn), .byte_valid(byteValid),
    .byte_ready(readyLsb), .flush(flush), .D(dLsb), .wr_en(wrEnLsb),
    .byte_idx(idxLsb), .words_written(wwLsb)
  );

  word_loader #(.LSB_FIRST(1'b0)) uMsb (
    .clk(clk), .rst(rst), .byte_in(byteIn), .byte_valid(byteValid),
    .byte_ready(readyMsb), .flush(flush), .D(dMsb), .wr_en(wrEnMsb),
    .byte_idx(idxMsb), .words_written(wwMsb)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mFill     = 1'b1;
    mIdx      = 0;
    mWr       = 1'b0;
    mCount    = 16'h0;
    mStageLsb = 32'h0;
    mStageMsb = 32'h0;
    heldLsb   = 32'h0;
    heldMsb   = 32'h0;
    qLsb.delete();
    qMsb.delete();
  endtask

  // Predicts the effect of the coming clock edge for the given inputs.
  task automatic modelStep(input logic [7:0] b, input logic v, input logic f);
    mWr = 1'b0;
    if (!mFill) begin
      mFill = 1'b1;
      if (mCount != 16'hFFFF) mCount = mCount + 16'd1;
    end else if (f) begin
      mIdx = 0;
    end else if (v) begin
      mStageLsb[mIdx*8 +: 8]     = b;
      mStageMsb[(3-mIdx)*8 +: 8] = b;
      if (mIdx == 3) begin
        qLsb.push_back(mStageLsb);
        qMsb.push_back(mStageMsb);
        mIdx  = 0;
        mFill = 1'b0;
        mWr   = 1'b1;
      end else begin
        mIdx = mIdx + 1;
      end
    end
  endtask

  // Compares both instances against the model; pops the scoreboard on wr_en.
  task automatic checkOutput();
    if (wrEnLsb === 1'b1) begin
      if (qLsb.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL lsbWrite: got wr_en=1 expected no pending word");
      end else begin
        heldLsb = qLsb.pop_front();
      end
    end
    if (wrEnMsb === 1'b1) begin
      if (qMsb.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL msbWrite: got wr_en=1 expected no pending word");
      end else begin
        heldMsb = qMsb.pop_front();
      end
    end
    check("lsbReady", {31'h0, readyLsb}, {31'h0, mFill});
    check("msbReady", {31'h0, readyMsb}, {31'h0, mFill});
    check("lsbIdx",   {30'h0, idxLsb},   mIdx);
    check("msbIdx",   {30'h0, idxMsb},   mIdx);
    check("lsbWrEn",  {31'h0, wrEnLsb},  {31'h0, mWr});
    check("msbWrEn",  {31'h0, wrEnMsb},  {31'h0, mWr});
    check("lsbD",     dLsb,              heldLsb);
    check("msbD",     dMsb,              heldMsb);
    check("lsbCount", {16'h0, wwLsb},    {16'h0, mCount});
    check("msbCount", {16'h0, wwMsb},    {16'h0, mCount});
  endtask

  // Called 1 ns after a rising edge: drive, advance one edge, check.
  task automatic applyStimulus(input logic [7:0] b, input logic v, input logic f);
    byteIn    = b;
    byteValid = v;
    flush     = f;
    modelStep(b, v, f);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Reset pulse placed between edges; outputs must clear before the next edge.
  task automatic asyncResetPulse(input string tag);
    #3;
    rst = 1'b1;
    #1;
    check({tag, "WrEnLsb"},  {31'h0, wrEnLsb}, 32'h0);
    check({tag, "WrEnMsb"},  {31'h0, wrEnMsb}, 32'h0);
    check({tag, "DLsb"},     dLsb,             32'h0);
    check({tag, "DMsb"},     dMsb,             32'h0);
    check({tag, "IdxLsb"},   {30'h0, idxLsb},  32'h0);
    check({tag, "CountLsb"}, {16'h0, wwLsb},   32'h0);
    check({tag, "CountMsb"}, {16'h0, wwMsb},   32'h0);
    check({tag, "ReadyLsb"}, {31'h0, readyLsb}, 32'h1);
    modelReset();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    byteIn     = 8'h0;
    byteValid  = 1'b0;
    flush      = 1'b0;
    modelReset();

    vecs[0]  = '{8'h11, 1'b1, 1'b0, 2'd1, 1'b0};
    vecs[1]  = '{8'h22, 1'b1, 1'b0, 2'd2, 1'b0};
    vecs[2]  = '{8'h33, 1'b1, 1'b0, 2'd3, 1'b0};
    vecs[3]  = '{8'h44, 1'b1, 1'b0, 2'd0, 1'b1};
    vecs[4]  = '{8'h55, 1'b1, 1'b0, 2'd0, 1'b0};
    vecs[5]  = '{8'h55, 1'b1, 1'b0, 2'd1, 1'b0};
    vecs[6]  = '{8'h66, 1'b1, 1'b0, 2'd2, 1'b0};
    vecs[7]  = '{8'h77, 1'b1, 1'b0, 2'd3, 1'b0};
    vecs[8]  = '{8'h88, 1'b1, 1'b0, 2'd0, 1'b1};
    vecs[9]  = '{8'h99, 1'b1, 1'b0, 2'd0, 1'b0};
    vecs[10] = '{8'hAA, 1'b1, 1'b0, 2'd1, 1'b0};
    vecs[11] = '{8'hBB, 1'b1, 1'b0, 2'd2, 1'b0};
    vecs[12] = '{8'hCC, 1'b1, 1'b1, 2'd0, 1'b0};
    vecs[13] = '{8'h01, 1'b1, 1'b0, 2'd1, 1'b0};
    vecs[14] = '{8'h02, 1'b1, 1'b0, 2'd2, 1'b0};
    vecs[15] = '{8'h03, 1'b1, 1'b0, 2'd3, 1'b0};
    vecs[16] = '{8'h04, 1'b1, 1'b0, 2'd0, 1'b1};
    vecs[17] = '{8'h00, 1'b0, 1'b1, 2'd0, 1'b0};
    vecs[18] = '{8'h00, 1'b0, 1'b0, 2'd0, 1'b0};
    vecs[19] = '{8'h12, 1'b1, 1'b0, 2'd1, 1'b0};
    vecs[20] = '{8'h00, 1'b0, 1'b1, 2'd0, 1'b0};
    vecs[21] = '{8'h00, 1'b0, 1'b0, 2'd0, 1'b0};
    vecs[22] = '{8'h5A, 1'b1, 1'b0, 2'd1, 1'b0};
    vecs[23] = '{8'h00, 1'b0, 1'b0, 2'd1, 1'b0};
    vecs[24] = '{8'hA5, 1'b1, 1'b0, 2'd2, 1'b0};
    vecs[25] = '{8'h00, 1'b0, 1'b0, 2'd2, 1'b0};
    vecs[26] = '{8'hC3, 1'b1, 1'b0, 2'd3, 1'b0};
    vecs[27] = '{8'h3C, 1'b1, 1'b0, 2'd0, 1'b1};
    vecs[28] = '{8'h00, 1'b0, 1'b0, 2'd0, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput();
    rst = 1'b0;

    // Main table-driven stream
    $display("[TB] vector table");
    for (int i = 0; i < 29; i++) begin
      applyStimulus(vecs[i].b, vecs[i].v, vecs[i].f);
      check($sformatf("vec%0dIdx", i), {30'h0, idxLsb}, {30'h0, vecs[i].expIdx});
      check($sformatf("vec%0dWr", i),  {31'h0, wrEnMsb}, {31'h0, vecs[i].expWr});
    end

    // Asynchronous reset while wr_en is high
    $display("[TB] reset during commit");
    applyStimulus(8'hDE, 1'b1, 1'b0);
    applyStimulus(8'hAD, 1'b1, 1'b0);
    applyStimulus(8'hBE, 1'b1, 1'b0);
    applyStimulus(8'hEF, 1'b1, 1'b0);
    check("commitBeforeReset", {31'h0, wrEnLsb}, 32'h1);
    asyncResetPulse("rstCommit");
    applyStimulus(8'h00, 1'b0, 1'b0);

    // Reset mid-word discards the partial word
    $display("[TB] reset mid-word");
    applyStimulus(8'hF0, 1'b1, 1'b0);
    applyStimulus(8'hF1, 1'b1, 1'b0);
    asyncResetPulse("rstMid");
    applyStimulus(8'hA1, 1'b1, 1'b0);
    applyStimulus(8'hB2, 1'b1, 1'b0);
    applyStimulus(8'hC3, 1'b1, 1'b0);
    applyStimulus(8'hD4, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0);

    // Counter saturation: preload near the top, then commit three words
    $display("[TB] counter saturation");
    force uLsb.wordsWritten_q = 16'hFFFE;
    force uMsb.wordsWritten_q = 16'hFFFE;
    #1;
    release uLsb.wordsWritten_q;
    release uMsb.wordsWritten_q;
    mCount = 16'hFFFE;
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 4; k++) begin
        applyStimulus(8'($urandom_range(0, 255)), 1'b1, 1'b0);
      end
      applyStimulus(8'h00, 1'b0, 1'b0);
      if (w >= 1) begin
        check($sformatf("satWord%0d", w + 1), {16'h0, wwLsb}, 32'h0000FFFF);
      end
    end

    // Random back-to-back stream with occasional gaps
    $display("[TB] random stream");
    for (int r = 0; r < 40; r++) begin
      applyStimulus(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0), 1'b0);
    end
    applyStimulus(8'h00, 1'b0, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b0);

    check("lsbQueueDrained", qLsb.size(), 32'h0);
    check("msbQueueDrained", qMsb.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/word_loader.md
WORD_LOADER -- requirements
Module: word_loader

Interface
REQ-001 The block SHALL provide parameter: LSB_FIRST, 1, byte order of assembly (1 = first byte lands in D[7:0]; 0 = first byte lands in D[31:24]).
REQ-002 The block SHALL provide port: clk  input  1  single clock; all flops rising-edge.
REQ-003 The block SHALL provide port: rst  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL provide port: byte_in  input  8  incoming data byte.
REQ-005 The block SHALL provide port: byte_valid  input  1  byte_in valid this cycle.
REQ-006 The block SHALL provide port: byte_ready  output  1  block accepts a byte this cycle.
REQ-007 The block SHALL provide port: flush  input  1  discard partially assembled word.
REQ-008 The block SHALL provide port: D  output  32  assembled word presented to the downstream 32-bit gated-clock register.
REQ-009 The block SHALL provide port: wr_en  output  1  write enable for the downstream register; one-cycle pulse per word.
REQ-010 The block SHALL provide port: byte_idx  output  2  number of bytes held in the current partial word.
REQ-011 The block SHALL provide port: words_written  output  16  count of committed words, saturating.

Function
REQ-012 The block SHALL implement two states: FILL and COMMIT.
REQ-013 byte_ready SHALL be 1 in FILL and 0 in COMMIT, decoded from state flops only (no combinational input-to-output path).
REQ-014 A byte SHALL be accepted on a rising edge where byte_valid=1 and byte_ready=1; byte_idx increments by 1 on acceptance.
REQ-015 Accepted bytes SHALL be written into a 32-bit staging register at lane byte_idx (LSB_FIRST=1) or lane 3-byte_idx (LSB_FIRST=0).
REQ-016 On acceptance of the 4th byte (byte_idx=3), the block SHALL, at that same edge, load D from staging (including the 4th byte), reset byte_idx to 0, and enter COMMIT.
REQ-017 In COMMIT, wr_en SHALL be 1 for exactly one cycle; the next edge SHALL return to FILL and increment words_written.
REQ-018 Latency SHALL be one cycle from 4th-byte acceptance edge to wr_en high; the downstream register captures D on the edge ending COMMIT.
REQ-019 wr_en SHALL be driven directly from a flop so that it changes only just after the rising clk edge, while clk is high, giving a glitch-free gated clock downstream.
REQ-020 D SHALL change only on entry to COMMIT and SHALL hold its value at all other times, including throughout and after the wr_en pulse.
REQ-021 Peak throughput SHALL be one word per 5 cycles (4 FILL acceptances + 1 COMMIT).
REQ-022 flush=1 in FILL SHALL clear byte_idx to 0 at the next edge; a byte handshaking in the same cycle SHALL be consumed and discarded.
REQ-023 flush=1 in COMMIT SHALL be ignored; the commit completes normally.
REQ-024 Staging lanes not yet written in the current word are don't-care and SHALL never reach D except via a 4-byte commit.
REQ-025 words_written SHALL saturate at 16'hFFFF and not wrap.

Reset
REQ-026 While rst=1 the block SHALL asynchronously force: state=FILL, wr_en=0, D=32'h0, byte_idx=0, staging=0, words_written=0; byte_ready=1 follows from state.
REQ-027 Reset asserted during COMMIT SHALL immediately drop wr_en to 0 without clocking the downstream register; the word is lost and not counted.
REQ-028 Reset asserted mid-word SHALL discard the partial word.

Verification
REQ-029 LSB_FIRST=1, bytes 11,22,33,44 on consecutive cycles -> next cycle wr_en=1 for one cycle, D=32'h44332211, words_written=1.
REQ-030 LSB_FIRST=0, same bytes -> D=32'h11223344; byte_ready=0 only during the wr_en cycle.
REQ-031 Two words back-to-back with byte_valid held high -> wr_en pulses exactly 5 cycles apart; no byte accepted during COMMIT; D of word 1 held until word 2 commit.
REQ-032 Bytes AA,BB, then flush with valid byte CC, then 01,02,03,04 -> single commit D=32'h04030201; byte_idx returns to 0 after flush.
REQ-033 rst pulsed asynchronously (between edges) while wr_en=1 -> wr_en, D, byte_idx, words_written all 0 before the next clk edge.
REQ-034 Force words_written to 16'hFFFE, commit 3 words -> count reads 16'hFFFF after the second commit and after the third.
